// File: rtl/seq_scan_ctrl.sv
`timescale 1ns/1ps
// Sequences a serial sequence detector over a parallel word: clears it, shifts bits LSB-first,
// and counts the cycles where the detector flags a match.
module seq_scan_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic [CNT_W-1:0] len,
   input  logic             det_out,
   output logic             det_in,
   output logic             det_rst,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CNT_W-1:0] bits_reg, bits_next;
   logic [CNT_W-1:0] match_reg, match_next;
   logic             sample_reg;
   logic [CNT_W-1:0] len_clamped;

   assign len_clamped = (len > WIDTH_C) ? WIDTH_C : len;

   // The detector is Moore, so its output lags one cycle behind the bit: sample
   // whenever the previous cycle was a SHIFT cycle (covers SHIFT after the first, and DRAIN).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         bits_reg   <= '0;
         match_reg  <= '0;
         sample_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         bits_reg   <= bits_next;
         match_reg  <= match_next;
         sample_reg <= (state_reg == SHIFT);
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      bits_next  = bits_reg;
      match_next = match_reg;
      if (sample_reg && det_out)
         match_next = match_reg + CNT_W'(1);
      case (state_reg)
         IDLE: begin
            if (start) begin
               match_next = '0;
               if (len != '0) begin
                  shift_next = data;
                  bits_next  = len_clamped;
                  state_next = CLR;
               end else begin
                  state_next = DONE;
               end
            end
         end
         CLR:   state_next = SHIFT;
         SHIFT: begin
            shift_next = shift_reg >> 1;
            bits_next  = bits_reg - CNT_W'(1);
            if (bits_reg == CNT_W'(1))
               state_next = DRAIN;
         end
         DRAIN: state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign det_in    = (state_reg == SHIFT) & shift_reg[0];
   assign det_rst   = reset | (state_reg == CLR);
   assign busy      = (state_reg == CLR) | (state_reg == SHIFT) | (state_reg == DRAIN);
   assign done      = (state_reg == DONE);
   assign match_cnt = match_reg;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for seq_scan_ctrl driving a 1,1,0 Moore detector model.
module tb_seq_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] data;
   logic [4:0]  len;
   logic        det_out;
   logic        det_in;
   logic        det_rst;
   logic        busy;
   logic        done;
   logic [4:0]  match_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] hist;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data      (data),
      .len       (len),
      .det_out   (det_out),
      .det_in    (det_in),
      .det_rst   (det_rst),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt)
   );

   // Detector model: out=1 when last three bits (oldest first) are 1,1,0
   always @(posedge clk) begin
      if (det_rst) hist <= 3'b000;
      else         hist <= {hist[1:0], det_in};
   end
   assign det_out = (hist == 3'b110);

   // Runs one job; checks {done,det_rst,busy,det_in} every cycle up to done,
   // match_cnt clearing at acceptance and the final count. Ends at the done cycle's negedge.
   task automatic run_job(input string name, input logic [15:0] d, input logic [4:0] l,
                          input int n_eff, input logic [4:0] exp_cnt, input bit inject);
      int done_k;
      logic [3:0] got, exp;
      logic exp_din;
      done_k = (n_eff == 0) ? 1 : n_eff + 3;
      @(negedge clk);
      start = 1'b1; data = d; len = l;
      @(negedge clk);
      start = 1'b0; data = 16'h0000; len = 5'd0;
      for (int k = 1; k <= done_k; k++) begin
         if (k > 1) @(negedge clk);
         if (inject && k == 4) begin
            start = 1'b1; data = 16'hFFFF; len = 5'd16;
         end
         if (inject && k == 5) start = 1'b0;
         exp_din = (k >= 2 && k <= n_eff + 1) ? d[k-2] : 1'b0;
         exp = {(k == done_k), (n_eff != 0 && k == 1), (n_eff != 0 && k <= n_eff + 2), exp_din};
         got = {done, det_rst, busy, det_in};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle T+%0d {done,det_rst,busy,det_in}: got %b expected %b", name, k, got, exp);
         end
         if (k == 1) begin
            n_checks++;
            if (match_cnt !== 5'd0) begin
               n_fail++;
               $display("FAIL %s match_cnt clear at acceptance: got %0d expected 0", name, match_cnt);
            end
         end
      end
      n_checks++;
      if (match_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, exp_cnt);
      end
      $display("job %s data=%h len=%0d match_cnt=%0d expected=%0d done at T+%0d", name, d, l, match_cnt, exp_cnt, done_k);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; data = 16'h0000; len = 5'd0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, det_in, det_rst, match_cnt} !== {4'b0001, 5'd0}) begin
         n_fail++;
         $display("FAIL reset_state {busy,done,det_in,det_rst,match_cnt}: got %b expected %b",
                  {busy, done, det_in, det_rst, match_cnt}, {4'b0001, 5'd0});
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, done, det_rst} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_release {busy,done,det_rst}: got %b expected 000", {busy, done, det_rst});
      end
      $display("reset: busy=%b done=%b det_rst=%b match_cnt=%0d", busy, done, det_rst, match_cnt);
   endtask

   task automatic test_basic();
      run_job("basic_0673", 16'h0673, 5'd11, 11, 5'd2, 1'b0);
      @(negedge clk);
      n_checks++;
      if (match_cnt !== 5'd2) begin
         n_fail++;
         $display("FAIL hold_after_done match_cnt: got %0d expected 2", match_cnt);
      end
      repeat (2) @(negedge clk);
      run_job("len15_36db", 16'h36DB, 5'd15, 15, 5'd5, 1'b0);
      repeat (2) @(negedge clk);
      run_job("clamp20_36db", 16'h36DB, 5'd20, 16, 5'd5, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_len_zero();
      run_job("basic_0673", 16'h0673, 5'd11, 11, 5'd2, 1'b0);
      repeat (2) @(negedge clk);
      run_job("len0", 16'hFFFF, 5'd0, 0, 5'd0, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_ignored();
      run_job("ignore_start", 16'h0673, 5'd11, 11, 5'd2, 1'b1);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL ignored_start_not_queued {busy,done}: got %b expected 00", {busy, done});
      end
   endtask

   task automatic test_reset_mid_shift();
      bit saw_done;
      @(negedge clk);
      start = 1'b1; data = 16'h0673; len = 5'd11;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);      // cycle T+7: SHIFT, one match already counted
      n_checks++;
      if ({busy, match_cnt} !== {1'b1, 5'd1}) begin
         n_fail++;
         $display("FAIL pre_reset {busy,match_cnt}: got %b expected %b", {busy, match_cnt}, {1'b1, 5'd1});
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, det_rst, det_in, match_cnt} !== {3'b010, 5'd0}) begin
         n_fail++;
         $display("FAIL mid_shift_reset {busy,det_rst,det_in,match_cnt}: got %b expected %b",
                  {busy, det_rst, det_in, match_cnt}, {3'b010, 5'd0});
      end
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      reset = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abandoned_job activity after reset: got %b expected 0", saw_done);
      end
      $display("reset mid-shift: match_cnt=%0d busy=%b", match_cnt, busy);
      run_job("after_reset", 16'h0673, 5'd11, 11, 5'd2, 1'b0);
   endtask

   task automatic test_back_to_back();
      // Previous job left match_cnt=2; next start lands in the IDLE cycle right after done
      run_job("b2b_second", 16'h36DB, 5'd15, 15, 5'd5, 1'b0);
      run_job("b2b_third", 16'h0673, 5'd11, 11, 5'd2, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_start_ignored();
      test_reset_mid_shift();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences the serial sequence-detector FSM (`in`/`out`, one bit per clock) over a parallel data word. A host loads a word and a bit count. The block clears the detector, shifts the bits in LSB-first, counts the cycles in which the detector asserts its output, and reports the match count with a one-cycle `done` pulse. It sits between a register-style host and a single detector instance, and owns the detector's `in` and reset.

## Interface
- `WIDTH`, 16, maximum number of bits scanned per job.
- `CNT_W`, 5, width of `len` and `match_cnt`; must satisfy 2^CNT_W > WIDTH.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `data`  in  WIDTH  word to scan; bit 0 is sent first.
- `len`  in  CNT_W  number of bits to scan; values > WIDTH are clamped to WIDTH.
- `det_out`  in  1  detector output; Moore, valid the cycle after a bit is sampled.
- `det_in`  out  1  drives detector `in`.
- `det_rst`  out  1  drives detector `reset`.
- `busy`  out  1  high in CLR, SHIFT and DRAIN.
- `done`  out  1  one-cycle pulse in DONE.
- `match_cnt`  out  CNT_W  matches counted in the last job; held until the next accepted `start`.

## Operation
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - `start`=1 and `len`≠0: latch `data` into the shift register, latch min(`len`,WIDTH) into the bit counter, clear `match_cnt`, go to CLR.
  - `start`=1 and `len`=0: clear `match_cnt`, go straight to DONE; no `det_rst` pulse.
- CLR: `det_rst`=1 for one cycle, `det_in`=0; go to SHIFT.
- SHIFT:
  - `det_in` = shift register bit 0; shift right by one each cycle.
  - Decrement the remaining-bit counter each cycle; after the last bit, go to DRAIN.
  - Sample `det_out` in every SHIFT cycle except the first (the first cycle shows the detector's reset state). Add 1 to `match_cnt` when `det_out`=1.
- DRAIN: sample `det_out` once more (result of the last bit), `det_in`=0; go to DONE.
- DONE: `done`=1, `busy`=0; go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- No saturation logic is needed: matches ≤ len ≤ WIDTH < 2^CNT_W.
- `det_rst` = `reset` OR (state==CLR), so the detector is held in reset while the block is.
- Reset (asynchronous, any state including mid-SHIFT):
  - state goes to IDLE.
  - `busy`=0, `done`=0, `match_cnt`=0, `det_in`=0.
  - The shift register and bit counter are cleared.
  - The job in progress is abandoned and no `done` is produced.

## Timing
- `start` sampled at edge T (in IDLE, len=N≥1). Then:
  - CLR during cycle T+1.
  - SHIFT during cycles T+2 … T+1+N; bit i is driven in cycle T+2+i.
  - DRAIN during cycle T+2+N.
  - `done`=1 during cycle T+3+N.
- Latency from `start` to `done` is N+3 cycles.
- With len=0, `done` is high in cycle T+1.
- The next `start` is accepted no earlier than the cycle after DONE (IDLE).
- `match_cnt` is valid from the `done` cycle onward and is stable until the next accepted `start`.
- `det_out` for bit i is counted in cycle T+3+i.
- All outputs except `det_rst` are registered, or decoded only from the state register.

## Test plan
Bench detector model: Moore, `out`=1 when the last three bits received are 1,1,0 (oldest first); synchronous reset.

- `data`=16'h0673, `len`=11 (stream 1,1,0,0,1,1,1,0,0,1,1) → `det_in` follows that stream in cycles T+2…T+12; `done` at T+14; `match_cnt`=2.
- `data`=16'h36DB, `len`=15 → `match_cnt`=5, `done` at T+18. Repeat with `len`=20 (clamped to 16) → `match_cnt`=5, `done` at T+19.
- `len`=0, `start`=1 → `done` at T+1, `match_cnt`=0, `det_rst` never pulses.
- `start` pulsed again during SHIFT with different `data` → ignored; first job's `match_cnt` and `done` timing unchanged.
- `reset` asserted mid-SHIFT of the 16'h0673 job → in the same cycle: `busy`=0, `det_rst`=1, `match_cnt`=0; no `done`. A new `start` after reset is released completes with `match_cnt`=2.
- Back-to-back jobs (`start` in the IDLE cycle right after `done`) → second job's `match_cnt` is cleared at acceptance, and `det_rst` pulses again in its CLR cycle.
